// File: rtl/inst_cache_responder.sv
// inst_cache_responder: direct-mapped read-only I-cache, slave end of the fetch bus.
// Optional hit/miss counters when INST_CACHE_STATS_EN is defined.
module inst_cache_responder #(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_rd,
  output logic [31:0]           o_inst,
  output logic                  o_busy,
  input  logic                  i_flush,
  output logic                  o_memReq,
  output logic [ADDR_WIDTH-1:0] o_memAddr,
  input  logic                  i_memAck,
  input  logic [31:0]           i_memData
`ifdef INST_CACHE_STATS_EN
  ,
  output logic [31:0]           o_hitCount,
  output logic [31:0]           o_missCount
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W - 2;
  localparam logic [OFF_W-1:0] BEAT_LAST = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    COMMIT
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS][LINE_WORDS];

  logic [OFF_W-1:0] beat_q;
  logic [IDX_W-1:0] lat_idx_q;
  logic [TAG_W-1:0] lat_tag_q;
  logic             flush_seen_q;

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             unused_addr_lsb;

  logic hit;
  logic start_fill;
  logic beat_we;
  logic commit;

  assign req_off = i_addr[OFF_W+1:2];
  assign req_idx = i_addr[OFF_W+IDX_W+1:OFF_W+2];
  assign req_tag = i_addr[ADDR_WIDTH-1:OFF_W+IDX_W+2];
  assign unused_addr_lsb = ^i_addr[1:0];

  assign hit = i_rd && valid_q[req_idx]
            && (tag_q[req_idx] == req_tag);

  // Next-state, bus outputs and write strobes
  always_comb begin
    state_d    = state_q;
    o_inst     = '0;
    o_busy     = 1'b0;
    o_memReq   = 1'b0;
    o_memAddr  = '0;
    start_fill = 1'b0;
    beat_we    = 1'b0;
    commit     = 1'b0;
    if (i_reset) begin
      o_busy  = 1'b1;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hit) begin
            o_inst = data_q[req_idx][req_off];
          end else if (i_rd) begin
            o_busy     = 1'b1;
            start_fill = 1'b1;
            state_d    = FILL;
          end
        end
        FILL: begin
          o_busy    = 1'b1;
          o_memReq  = 1'b1;
          o_memAddr = {lat_tag_q, lat_idx_q,
                       beat_q, 2'b00};
          if (i_memAck) begin
            beat_we = 1'b1;
            if (beat_q == BEAT_LAST) begin
              state_d = COMMIT;
            end
          end
        end
        COMMIT: begin
          o_busy  = 1'b1;
          commit  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Fill bookkeeping and valid bits; flush wins over any set
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      valid_q      <= '0;
      beat_q       <= '0;
      flush_seen_q <= 1'b0;
      lat_idx_q    <= '0;
      lat_tag_q    <= '0;
    end else begin
      if (start_fill) begin
        lat_idx_q          <= req_idx;
        lat_tag_q          <= req_tag;
        beat_q             <= '0;
        flush_seen_q       <= 1'b0;
        valid_q[req_idx]   <= 1'b0;
      end
      if (beat_we) begin
        beat_q <= beat_q + OFF_W'(1);
      end
      if (i_flush && state_q != IDLE) begin
        flush_seen_q <= 1'b1;
      end
      if (commit && !flush_seen_q && !i_flush) begin
        valid_q[lat_idx_q] <= 1'b1;
      end
      if (i_flush) begin
        valid_q <= '0;
      end
    end
  end

  // Line storage: data per beat, tag at commit
  always_ff @(posedge i_clock) begin
    if (beat_we) begin
      data_q[lat_idx_q][beat_q] <= i_memData;
    end
    if (commit) begin
      tag_q[lat_idx_q] <= lat_tag_q;
    end
  end

`ifdef INST_CACHE_STATS_EN
  // Hit cycles and line fills, free-running
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_hitCount  <= '0;
      o_missCount <= '0;
    end else begin
      if (state_q == IDLE && hit) begin
        o_hitCount <= o_hitCount + 32'd1;
      end
      if (start_fill) begin
        o_missCount <= o_missCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_cache_responder.sv
// tb_inst_cache_responder: directed bench with a line-level cache model.
// Checks every cycle plus per-fetch latency against hand-computed values.
module tb_inst_cache_responder;

  localparam int SETS = 64;
  localparam int LW   = 4;
  localparam int AW   = 32;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_rd = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_memAck = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_memData = '0;
  logic [31:0] o_inst;
  logic [31:0] o_memAddr;
  logic        o_busy;
  logic        o_memReq;
`ifdef INST_CACHE_STATS_EN
  logic [31:0] o_hitCount;
  logic [31:0] o_missCount;
`endif

  int checks = 0;
  int errors = 0;
  int wait_n = 0;
  int hits_m = 0;
  int misses_m = 0;

  bit          mv [SETS];
  logic [21:0] mt [SETS];

  inst_cache_responder #(
    .SETS(SETS),
    .LINE_WORDS(LW),
    .ADDR_WIDTH(AW)
  ) dut (
    .i_clock  (clk),
    .i_reset  (i_reset),
    .i_addr   (i_addr),
    .i_rd     (i_rd),
    .o_inst   (o_inst),
    .o_busy   (o_busy),
    .i_flush  (i_flush),
    .o_memReq (o_memReq),
    .o_memAddr(o_memAddr),
    .i_memAck (i_memAck),
    .i_memData(i_memData)
`ifdef INST_CACHE_STATS_EN
    ,
    .o_hitCount (o_hitCount),
    .o_missCount(o_missCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, req);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) mv[s] = 1'b0;
  endtask

  // Fetch one address, count busy cycles, update line model
  task automatic fetch(input logic [31:0] a,
                       input int w,
                       input bit flush_mid,
                       output int lat);
    int  idx;
    int  pen;
    int  expv;
    bit  hitp;
    bit  fired;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    wait_n  = w;
    i_addr  = a;
    i_rd    = 1'b1;
    idx  = int'(a[9:4]);
    hitp = mv[idx] && (mt[idx] == a[31:10]);
    pen  = LW * (w + 1) + 2;
    expv = hitp ? 0 : (flush_mid ? 2 * pen : pen);
    if (!hitp) misses_m += flush_mid ? 2 : 1;
    lat   = 0;
    fired = 1'b0;
    forever begin
      @(negedge clk);
      if (i_flush) i_flush = 1'b0;
      if (!o_busy) break;
      lat++;
      if (flush_mid && !fired && o_memReq &&
          o_memAddr == ((a & 32'hFFFF_FFF0) + 32'h8)) begin
        i_flush = 1'b1;
        fired   = 1'b1;
      end
      if (lat > 300) break;
    end
    chk("fetch_latency", 32'(lat), 32'(expv));
    if (flush_mid) model_clear();
    mv[idx] = 1'b1;
    mt[idx] = a[31:10];
  endtask

  // Per-cycle compare and backing-memory responder
  initial begin : cmp
    int         wcnt;
    logic [1:0] rbeat;
    wcnt  = 0;
    rbeat = '0;
    forever begin
      @(negedge clk);
      if (i_reset) begin
        chk("rst_busy", 32'(o_busy), 32'd1);
        chk("rst_inst", o_inst, 32'd0);
        chk("rst_req", 32'(o_memReq), 32'd0);
        hits_m = 0;
      end else begin
        if (!i_rd) begin
          chk("idle_busy", 32'(o_busy), 32'd0);
          chk("idle_inst", o_inst, 32'd0);
          chk("idle_req", 32'(o_memReq), 32'd0);
        end else if (!o_busy) begin
          chk("hit_inst", o_inst, {i_addr[31:2], 2'b00});
          chk("hit_req", 32'(o_memReq), 32'd0);
          hits_m++;
        end
        if (o_memReq) begin
          chk("mem_addr", o_memAddr,
              {i_addr[31:4], rbeat, 2'b00});
        end
      end
      if (o_memReq && !i_reset) begin
        if (wcnt == wait_n) begin
          i_memAck  = 1'b1;
          i_memData = o_memAddr;
          wcnt      = 0;
          rbeat     = rbeat + 2'd1;
        end else begin
          i_memAck = 1'b0;
          wcnt++;
        end
      end else begin
        i_memAck = 1'b0;
        wcnt     = 0;
        rbeat    = '0;
      end
    end
  end

  initial begin : stim
    int lat;
    bit found;
    model_clear();
    for (int s = 0; s < SETS; s++) mt[s] = '0;
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1'b0;

    fetch(32'h104, 0, 1'b0, lat);
    chk("cold_lat", 32'(lat), 32'd6);
    chk("cold_inst", o_inst, 32'h104);

    fetch(32'h10C, 0, 1'b0, lat);
    chk("same_line_lat", 32'(lat), 32'd0);
    chk("same_line_inst", o_inst, 32'h10C);
    chk("same_line_req", 32'(o_memReq), 32'd0);

    fetch(32'h500, 0, 1'b0, lat);
    chk("evict_lat", 32'(lat), 32'd6);
    chk("evict_inst", o_inst, 32'h500);
    fetch(32'h100, 0, 1'b0, lat);
    chk("reload_lat", 32'(lat), 32'd6);

    fetch(32'h2000, 3, 1'b0, lat);
    chk("wait_lat", 32'(lat), 32'd18);
    chk("wait_inst", o_inst, 32'h2000);

    fetch(32'h3048, 0, 1'b1, lat);
    chk("flush_fill_lat", 32'(lat), 32'd12);
    fetch(32'h3040, 0, 1'b0, lat);
    chk("refill_hit_lat", 32'(lat), 32'd0);
    fetch(32'h100, 0, 1'b0, lat);
    chk("flushed_miss_lat", 32'(lat), 32'd6);
    fetch(32'h100, 0, 1'b0, lat);
    chk("rehit_lat", 32'(lat), 32'd0);

    @(posedge clk);
    #1;
    i_flush = 1'b1;
    @(negedge clk);
    chk("flush_hit_busy", 32'(o_busy), 32'd0);
    chk("flush_hit_inst", o_inst, 32'h100);
    model_clear();
    fetch(32'h100, 0, 1'b0, lat);
    chk("idle_flush_miss_lat", 32'(lat), 32'd6);

    @(posedge clk);
    #1;
    i_flush = 1'b1;
    i_rd    = 1'b0;
    @(posedge clk);
    #1;
    i_flush = 1'b0;
    model_clear();
    i_addr  = 32'h100;
    i_rd    = 1'b1;
    found   = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (o_memReq && o_memAddr == 32'h104) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_beat1", 32'(found), 32'd1);
    i_reset  = 1'b1;
    misses_m = 0;
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    i_rd    = 1'b0;
    chk("post_rst_req", 32'(o_memReq), 32'd0);
    chk("post_rst_addr", o_memAddr, 32'd0);
`ifdef INST_CACHE_STATS_EN
    chk("post_rst_hits", o_hitCount, 32'd0);
    chk("post_rst_miss", o_missCount, 32'd0);
`endif
    fetch(32'h100, 0, 1'b0, lat);
    chk("post_rst_miss_lat", 32'(lat), 32'd6);
    chk("post_rst_inst", o_inst, 32'h100);

    @(posedge clk);
    #1;
    i_rd = 1'b0;
    @(posedge clk);
    #1;
`ifdef INST_CACHE_STATS_EN
    chk("hit_count", o_hitCount, 32'(hits_m));
    chk("miss_count", o_missCount, 32'(misses_m));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_cache_responder.md
Name: inst_cache_responder

Overview:
- Responder (slave) end of the instruction-fetch bus: accepts the fetch address and read strobe from the IF stage and returns the instruction word.
- Direct-mapped, read-only instruction cache.
- On a hit, data is returned combinationally in the same cycle.
- On a miss, a fill FSM stalls the fetch stage and refills the whole line from backing memory through a req/ack word handshake.

Parameters:
- SETS, 64, number of cache lines; power of two, >= 2.
- LINE_WORDS, 4, 32-bit words per line; power of two, >= 2.
- ADDR_WIDTH, 32, byte-address width of the fetch and backing buses.

Ports:
- i_clock  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  synchronous reset, active-high.
- i_addr  in  ADDR_WIDTH  fetch byte address from IF; bits [1:0] ignored.
- i_rd  in  1  fetch request.
- o_inst  out  32  instruction word.
- o_busy  out  1  fetch not satisfied this cycle; IF must hold i_addr.
- i_flush  in  1  invalidate all lines (fence.i).
- o_memReq  out  1  backing read request.
- o_memAddr  out  ADDR_WIDTH  backing word address, bits [1:0] = 0.
- i_memAck  in  1  backing data valid for the current o_memAddr.
- i_memData  in  32  backing read data.

Behaviour:
- Address split:
  - offset = addr[log2(LINE_WORDS)+1:2]
  - index = next log2(SETS) bits
  - tag = remaining upper bits
- Storage: flop-based arrays with asynchronous read.
  - valid[SETS], tag[SETS], data[SETS][LINE_WORDS].
- States: IDLE, FILL, COMMIT.
- IDLE:
  - hit = i_rd & valid[index] & tag[index]==addrTag.
  - On hit: o_inst = data[index][offset], o_busy=0.
  - On i_rd & !hit: o_busy=1; latch index/tag; beat counter=0; go to FILL.
  - i_rd=0: o_busy=0, o_inst=0, no state change.
- FILL:
  - o_busy=1, o_memReq=1, o_memAddr = {latchedTag, latchedIndex, beat, 2'b00}.
  - o_memAddr is stable until i_memAck.
  - On i_memAck: write i_memData into data[latchedIndex][beat]; beat++.
  - On the last beat's ack: go to COMMIT.
  - o_memReq may stay high across consecutive beats.
- COMMIT:
  - o_busy=1, o_memReq=0.
  - Write tag[latchedIndex]; set valid[latchedIndex] unless a flush occurred during the fill.
  - Go to IDLE.
  - Next cycle the held address hits: miss penalty = LINE_WORDS ack cycles + 2 cycles.
- Flush:
  - i_flush in any state clears all valid bits at the next edge.
  - If asserted in FILL or COMMIT, a sticky flag suppresses setting valid in COMMIT; the fill itself completes because backing beats are not abortable.
  - Flush and hit in the same cycle: this cycle's hit is served; the next access misses.
- Line replacement: a miss overwrites data in place. valid[latchedIndex] is cleared on entering FILL, so a partially-filled line is never hit.
- Reset (any state, including mid-fill):
  - State IDLE, all valid=0, beat=0, flush flag=0, o_memReq=0, o_memAddr=0.
  - While i_reset=1: o_busy=1, o_inst=0.
  - A backing ack arriving after reset is ignored.
- Master contract: i_addr/i_rd are stable while o_busy=1. Behaviour on violation is undefined, but must not deadlock: the fill completes and the FSM returns to IDLE.
- Backing-memory contract: i_memAck is honoured only while o_memReq=1.

Optional Feature:
- Macro INST_CACHE_STATS_EN.
- Defined:
  - Adds outputs o_hitCount (32) and o_missCount (32), reset to 0.
  - o_hitCount increments each IDLE cycle with hit; o_missCount increments on each IDLE->FILL transition.
  - Both wrap modulo 2^32. Neither counts while i_reset=1.
- Not defined: ports and counters absent; all other behaviour identical.

Test Plan:
- Cold miss (SETS=64, LINE_WORDS=4):
  - Stimulus: after reset, i_rd=1, i_addr=0x0000_0104; backing acks every cycle with data = address.
  - Required: o_memAddr sequence 0x100, 0x104, 0x108, 0x10C; o_busy high 6 cycles; then o_inst=0x0000_0104, o_busy=0.
- Same-line hit:
  - Stimulus: then i_addr=0x0000_010C.
  - Required: o_inst=0x0000_010C in the same cycle, o_busy=0, o_memReq stays 0.
- Conflict eviction:
  - Stimulus: i_addr=0x0000_0500 (same index, new tag).
  - Required: refill 0x500..0x50C; a subsequent 0x0000_0100 misses again.
- Wait states:
  - Stimulus: ack delayed 3 cycles per beat.
  - Required: o_memReq and o_memAddr stable until each ack; total busy = 4*4 + 2 cycles.
- Flush:
  - Stimulus: i_flush pulse during beat 2 of a fill.
  - Required: fill completes, line stays invalid, the next cycle re-misses the same address; a flush in IDLE makes the previously hit 0x100 miss.
- Reset mid-fill:
  - Stimulus: i_reset during beat 1.
  - Required: o_memReq=0 next cycle, no commit, fetch of 0x100 after reset misses.
  - With INST_CACHE_STATS_EN: counters read 0 after reset; hit/miss totals match the scenarios.
